// File: rtl/aoi_sop_pipe_if.sv
// Stream, configuration and sweep-control bundle for aoi_sop_pipe.
// master = environment side, slave = the evaluator.
interface aoi_sop_pipe_if #(
    parameter int N_IN    = 5,
    parameter int N_TERMS = 2
);
    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    logic              cfg_we;
    logic [CW-1:0]     cfg_idx;
    logic [N_IN-1:0]   cfg_mask;

    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   x_in;

    logic              out_valid;
    logic              out_ready;
    logic              y;

    logic              sweep_start;
    logic              sweep_busy;
    logic              sweep_done;
    logic [N_IN:0]     sweep_ones;

    modport master (
        output cfg_we, cfg_idx, cfg_mask,
        output in_valid, x_in,
        output out_ready,
        output sweep_start,
        input  in_ready, out_valid, y,
        input  sweep_busy, sweep_done, sweep_ones
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_mask,
        input  in_valid, x_in,
        input  out_ready,
        input  sweep_start,
        output in_ready, out_valid, y,
        output sweep_busy, sweep_done, sweep_ones
    );
endinterface

// File: rtl/aoi_sop_pipe.sv
// Two-stage elastic AND-OR(-INVERT) evaluator with programmable product
// terms and a self-sweep engine that pushes every input vector through the
// pipeline and counts the results equal to 1.
module aoi_sop_pipe #(
    parameter int N_IN    = 5,
    parameter int N_TERMS = 2,
    parameter int INV     = 1
) (
    input  logic              clk,
    input  logic              rst_b,
    aoi_sop_pipe_if.slave     bus
);
    localparam logic INV_BIT = (INV != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A term only fires when its mask is non-empty; an empty mask is "off",
    // never a constant 1.
    function automatic logic term_hit(input logic [N_IN-1:0] mask,
                                      input logic [N_IN-1:0] vec);
        term_hit = (mask != {N_IN{1'b0}}) && ((vec & mask) == mask);
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [N_IN-1:0]     mask_r [N_TERMS];
    logic [N_IN-1:0]     cnt_r;
    logic [N_IN:0]       ones_r;
    logic                done_r;

    logic                a_valid_r;
    logic                a_tag_r;
    logic [N_TERMS-1:0]  a_terms_r;

    logic                b_valid_r;
    logic                b_y_r;
    logic                b_tag_r;

    logic                idle_s;
    logic                a_adv_s;
    logic                b_adv_s;
    logic                src_valid_s;
    logic                src_tag_s;
    logic [N_IN-1:0]     src_vec_s;
    logic                accept_s;
    logic                start_s;
    logic                cnt_last_s;
    logic                consume_s;
    logic                last_s;
    logic [N_TERMS-1:0]  terms_s;
    logic [N_TERMS-1:0]  cfg_sel_s;
    logic                y_s;

    // Pipeline advance chain: a stage moves when empty or when its consumer moves.
    always_comb begin
        idle_s     = (state_r == ST_IDLE);
        b_adv_s    = ~b_valid_r | bus.out_ready;
        a_adv_s    = ~a_valid_r | b_adv_s;
        consume_s  = b_valid_r & bus.out_ready;
        start_s    = idle_s & bus.sweep_start;
        cnt_last_s = (cnt_r == {N_IN{1'b1}});
        y_s        = (|a_terms_r) ^ INV_BIT;
        // Final sweep result leaves while no other tagged vector remains behind it.
        last_s     = (state_r == ST_DRAIN) & consume_s & b_tag_r & ~(a_valid_r & a_tag_r);
    end

    // Vector source select: external stream when idle, sweep counter otherwise.
    always_comb begin
        src_valid_s = 1'b0;
        src_tag_s   = 1'b0;
        src_vec_s   = {N_IN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                src_valid_s = bus.in_valid;
                src_tag_s   = 1'b0;
                src_vec_s   = bus.x_in;
            end
            ST_SWEEP: begin
                src_valid_s = 1'b1;
                src_tag_s   = 1'b1;
                src_vec_s   = cnt_r;
            end
            ST_DRAIN: begin
                src_valid_s = 1'b0;
                src_tag_s   = 1'b0;
                src_vec_s   = cnt_r;
            end
            default: begin
                src_valid_s = 1'b0;
                src_tag_s   = 1'b0;
                src_vec_s   = {N_IN{1'b0}};
            end
        endcase
        accept_s = src_valid_s & a_adv_s;
    end

    // Product-term evaluation against the masks as they stand this cycle.
    always_comb begin
        terms_s = {N_TERMS{1'b0}};
        for (int t = 0; t < N_TERMS; t++) begin
            terms_s[t] = term_hit(mask_r[t], src_vec_s);
        end
    end

    // Decode of mask writes; out-of-range indices and writes during a sweep are dropped.
    always_comb begin
        cfg_sel_s = {N_TERMS{1'b0}};
        for (int t = 0; t < N_TERMS; t++) begin
            if (bus.cfg_we && idle_s && (int'(bus.cfg_idx) == t)) begin
                cfg_sel_s[t] = 1'b1;
            end else begin
                cfg_sel_s[t] = 1'b0;
            end
        end
    end

    // Sweep controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_SWEEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (accept_s && cnt_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sweep controller state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Term mask register file; all-zero after reset so every result equals INV.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int t = 0; t < N_TERMS; t++) begin
                mask_r[t] <= {N_IN{1'b0}};
            end
        end else begin
            for (int t = 0; t < N_TERMS; t++) begin
                if (cfg_sel_s[t]) begin
                    mask_r[t] <= bus.cfg_mask;
                end
            end
        end
    end

    // Sweep vector counter: cleared on start, steps once per injected vector.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_r <= {N_IN{1'b0}};
        end else if (start_s) begin
            cnt_r <= {N_IN{1'b0}};
        end else if ((state_r == ST_SWEEP) && accept_s) begin
            cnt_r <= cnt_r + N_IN'(1);
        end
    end

    // Stage A: latch term bits and sweep tag of the accepted vector.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_valid_r <= 1'b0;
            a_tag_r   <= 1'b0;
            a_terms_r <= {N_TERMS{1'b0}};
        end else if (a_adv_s) begin
            a_valid_r <= accept_s;
            a_tag_r   <= src_tag_s & accept_s;
            a_terms_r <= terms_s;
        end
    end

    // Stage B: reduce terms to y; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            b_valid_r <= 1'b0;
            b_y_r     <= 1'b0;
            b_tag_r   <= 1'b0;
        end else if (b_adv_s) begin
            b_valid_r <= a_valid_r;
            b_y_r     <= y_s;
            b_tag_r   <= a_tag_r;
        end
    end

    // Count of consumed sweep results equal to 1; kept until the next sweep starts.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ones_r <= {(N_IN+1){1'b0}};
        end else if (start_s) begin
            ones_r <= {(N_IN+1){1'b0}};
        end else if (consume_s && b_tag_r && b_y_r) begin
            ones_r <= ones_r + (N_IN+1)'(1);
        end
    end

    // One-cycle completion pulse after the final sweep result is consumed.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
        end
    end

    assign bus.in_ready   = idle_s & a_adv_s;
    assign bus.out_valid  = b_valid_r;
    assign bus.y          = b_y_r;
    assign bus.sweep_busy = ~idle_s;
    assign bus.sweep_done = done_r;
    assign bus.sweep_ones = ones_r;

endmodule

// File: tb/tb_aoi_sop_pipe.sv
// Directed bench for aoi_sop_pipe (N_IN=5, N_TERMS=2, INV=1).
module tb_aoi_sop_pipe;
    localparam int N_IN    = 5;
    localparam int N_TERMS = 2;
    localparam int INV     = 1;

    typedef struct {
        logic        y;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    aoi_sop_pipe_if #(.N_IN(N_IN), .N_TERMS(N_TERMS)) bus ();

    aoi_sop_pipe #(.N_IN(N_IN), .N_TERMS(N_TERMS), .INV(INV)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          zeros_seen = 0;
    int          res_cnt = 0;
    int          sw_idx = 0;
    int          sw_ones = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          no_bp = 1'b1;
    bit          hold_pend = 1'b0;
    logic        hold_y = 1'b0;
    logic [4:0]  m_mask [N_TERMS];
    exp_t        q [$];
    logic        y_hist [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: y = INV ? ~f : f, where f is the OR of enabled AND terms.
    function automatic logic model_y(input logic [4:0] x);
        logic f;
        f = 1'b0;
        for (int t = 0; t < N_TERMS; t++) begin
            if (m_mask[t] != 5'd0 && (x & m_mask[t]) == m_mask[t]) f = 1'b1;
        end
        return (INV != 0) ? ~f : f;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor at the falling edge: results, stall stability, acceptances, config.
    always @(negedge clk) begin
        if (rst_b) begin
            if (bus.out_valid && bus.out_ready) begin
                y_hist.push_back(bus.y);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("y_stream", bus.y, e.y);
                    if (no_bp) check("latency", cyc - e.c, 2);
                    if (!bus.y) zeros_seen++;
                    res_cnt++;
                end else begin
                    check("y_sweep", bus.y, model_y(5'(sw_idx)));
                    if (bus.y) sw_ones++;
                    sw_idx++;
                end
            end
            if (hold_pend) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_y", bus.y, hold_y);
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_y    = bus.y;
            if (bus.in_valid && bus.in_ready) q.push_back('{model_y(bus.x_in), cyc});
            if (bus.cfg_we && !bus.sweep_busy && int'(bus.cfg_idx) < N_TERMS)
                m_mask[int'(bus.cfg_idx)] = bus.cfg_mask;
            if (bus.sweep_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] x, input bit bp);
        int  tries;
        bit  ok;
        tries = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.x_in = x;
        while (!ok) begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            ok = bus.in_ready;
            step();
            tries++;
            if (!ok && tries > 200) begin
                check("accept_timeout", 0, 1);
                ok = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic stream(input bit bp);
        for (int i = 0; i < 32; i++) send(5'(i), bp);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        repeat (6) step();
    endtask

    task automatic cfg(input int idx, input logic [4:0] m);
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 1'(idx);
        bus.cfg_mask = m;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic run_sweep(input bit bp, input bit chk_time);
        int k;
        int t;
        int d0;
        sw_idx = 0;
        sw_ones = 0;
        d0 = done_cnt;
        t = 0;
        bus.out_ready = 1'b1;
        bus.sweep_start = 1'b1;
        k = cyc;
        step();
        bus.sweep_start = 1'b0;
        check("busy_set", bus.sweep_busy, 1);
        while (done_cnt == d0 && t < 2000) begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        bus.out_ready = 1'b1;
        check("done_seen", done_cnt, d0 + 1);
        if (chk_time) check("done_time", done_cyc - k, 35);
        repeat (4) step();
        check("done_single", done_cnt, d0 + 1);
        check("busy_clr", bus.sweep_busy, 0);
        check("sweep_ones", bus.sweep_ones, 21);
        check("sweep_cnt_tb", sw_ones, 21);
        check("sweep_vecs", sw_idx, 32);
    endtask

    initial begin
        for (int t = 0; t < N_TERMS; t++) m_mask[t] = 5'd0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_mask = 5'd0;
        bus.in_valid = 1'b0;
        bus.x_in = 5'd0;
        bus.out_ready = 1'b1;
        bus.sweep_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;

        // Reset values
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y", bus.y, 0);
        check("rst_busy", bus.sweep_busy, 0);
        check("rst_done", bus.sweep_done, 0);
        check("rst_ones", bus.sweep_ones, 0);

        // Unconfigured: all results are 1
        no_bp = 1'b1;
        zeros_seen = 0;
        stream(1'b0);
        drain();
        check("unconf_zeros", zeros_seen, 0);
        check("unconf_q_empty", q.size(), 0);

        // Classic AOI: terms x1&x2 and x3&x4&x5 -> 11 zeros
        cfg(0, 5'b11000);
        cfg(1, 5'b00111);
        zeros_seen = 0;
        stream(1'b0);
        drain();
        check("aoi_zeros", zeros_seen, 11);
        check("aoi_q_empty", q.size(), 0);

        // Sweep with out_ready held high
        run_sweep(1'b0, 1'b1);

        // Back-pressured stream: nothing lost or duplicated
        no_bp = 1'b0;
        res_cnt = 0;
        sw_idx = 0;
        stream(1'b1);
        drain();
        check("bp_results", res_cnt, 32);
        check("bp_q_empty", q.size(), 0);
        check("bp_no_extra", sw_idx, 0);

        // Back-pressured sweep
        run_sweep(1'b1, 1'b0);
        no_bp = 1'b1;

        // Mask write coinciding with acceptance of vector 7
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.x_in = 5'd7;
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 1'b1;
        bus.cfg_mask = 5'd0;
        step();
        bus.cfg_we = 1'b0;
        step();
        bus.in_valid = 1'b0;
        y_hist.delete();
        drain();
        check("cfg_hist_len", y_hist.size(), 2);
        if (y_hist.size() == 2) begin
            check("cfg_old_mask", y_hist[0], 0);
            check("cfg_new_mask", y_hist[1], 1);
        end

        // Reset in the middle of a sweep
        cfg(1, 5'b00111);
        begin
            int d0;
            d0 = done_cnt;
            sw_idx = 0;
            bus.out_ready = 1'b1;
            bus.sweep_start = 1'b1;
            step();
            bus.sweep_start = 1'b0;
            repeat (10) step();
            rst_b = 1'b0;
            #1;
            check("mid_rst_in_ready", bus.in_ready, 1);
            check("mid_rst_out_valid", bus.out_valid, 0);
            check("mid_rst_y", bus.y, 0);
            check("mid_rst_busy", bus.sweep_busy, 0);
            check("mid_rst_done", bus.sweep_done, 0);
            check("mid_rst_ones", bus.sweep_ones, 0);
            repeat (3) step();
            check("mid_rst_no_done", done_cnt, d0);
            q.delete();
            for (int t = 0; t < N_TERMS; t++) m_mask[t] = 5'd0;
            rst_b = 1'b1;
            step();
            check("post_rst_no_done", done_cnt, d0);
        end
        cfg(0, 5'b11000);
        cfg(1, 5'b00111);
        run_sweep(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/aoi_sop_pipe.md
# aoi_sop_pipe

Parametrised, pipelined AND-OR-INVERT evaluator with run-time programmable product terms and a built-in exhaustive sweep mode. It generalises the fixed 5-input, 2-term AOI cell to N_IN inputs, N_TERMS programmable terms and a selectable output inversion. A valid/ready stream interface sits on each side. A self-sweep engine drives all 2^N_IN input vectors through the pipeline and counts the 1 results, for on-chip function checking.

## Interface
- N_IN, 5: number of inputs (2..8).
- N_TERMS, 2: number of product terms (1..8). CW = max(1, clog2(N_TERMS)).
- INV, 1: 1 gives AND-OR-INVERT; 0 gives AND-OR.

- clk  in  1  rising-edge clock.
- rst_b  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  write the term mask.
- cfg_idx  in  CW  term index to write. Writes with cfg_idx >= N_TERMS are ignored.
- cfg_mask  in  N_IN  term mask. Bit i = 1 includes x_in[i] in the term.
- in_valid  in  1  input vector valid.
- in_ready  out  1  pipeline accepts the vector.
- x_in  in  N_IN  input vector. x_in[N_IN-1] corresponds to the classic x_in1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y  out  1  result.
- sweep_start  in  1  one-cycle request to start a sweep.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the sweep completes.
- sweep_ones  out  N_IN+1  count of y==1 results in the last sweep.

## Operation
- Term t = AND of x bits selected by mask[t]. An all-zero mask means the term is disabled and contributes 0; it is not treated as a constant 1.
- f = OR of all terms. y = INV ? ~f : f.
- The mask register file resets to all zeros. After reset, every result is y = INV.
- Stage A captures the N_TERMS term bits when a vector is accepted. The masks used are the values before any cfg_we in that same cycle.
- Stage B captures y, out_valid and a sweep tag.
- Elastic pipeline. A stage advances when it is empty or when its downstream stage advances. There are no bubbles while out_ready = 1.
- y and out_valid stay stable while out_valid = 1 and out_ready = 0.
- Vector source: x_in when the FSM is in IDLE, the sweep counter otherwise.
- FSM states:
  - IDLE: in_ready follows the pipeline. sweep_start moves to SWEEP, clears sweep_ones and the counter, and sets sweep_busy the next cycle.
  - SWEEP: in_ready = 0. The counter injects vectors 0 .. 2^N_IN-1, one per cycle that stage A can advance, each tagged as a sweep vector. After injecting 2^N_IN-1, go to DRAIN.
  - DRAIN: no injection. When the last tagged result is consumed (out_valid & out_ready), pulse sweep_done, clear sweep_busy and return to IDLE.
- sweep_ones increments on each consumed tagged result with y = 1. Its maximum is 2^N_IN, which is why it is N_IN+1 bits wide. It holds its value until the next sweep_start.
- Untagged vectors already in flight at sweep_start complete normally and are not counted.
- While sweep_busy = 1, cfg_we and sweep_start are ignored.
- A sweep_start and an external in_valid in the same IDLE cycle: the external vector is accepted first (untagged) and the sweep starts.

## Timing
- Reset values: in_ready 1, out_valid 0, y 0, sweep_busy 0, sweep_done 0, sweep_ones 0. FSM in IDLE, counter 0.
- Latency: a vector accepted in cycle n produces its result on out_valid/y in cycle n+2, with out_ready held high.
- Throughput is 1 result per cycle.
- A cfg_we in cycle n affects vectors accepted in cycle n+1 and later.
- Sweep duration with out_ready = 1: sweep_done pulses 2^N_IN + 2 cycles after the first injection.
- Assertion of rst_b mid-sweep or mid-stream clears the whole pipeline, the FSM and sweep_ones immediately. No sweep_done pulse is produced.

## Test plan
- Reset, with no configuration: stream x = 0..31 with out_ready = 1 → y = 1 on all 32 results, each appearing 2 cycles after its acceptance.
- Write masks 5'b11000 (term 0) and 5'b00111 (term 1), INV = 1, stream 0..31 → y matches ~((x1&x2)|(x3&x4&x5)). Exactly 11 zeros: vectors 7, 15, 23 and 24..31.
- Same configuration, then sweep_start → sweep_busy high, sweep_ones = 21, one sweep_done pulse at 34 cycles.
- Random out_ready back-pressure during a stream → no result is lost or duplicated, and y is stable while stalled. Repeat during a sweep → sweep_ones is still 21.
- cfg_we changing term 1 to 0 in the same cycle that vector 7 is accepted → vector 7 gives y = 0 (old mask). Vector 7 accepted the next cycle gives y = 1.
- rst_b pulled low at sweep vector 10 → all outputs at their reset values, no sweep_done. A new sweep afterwards gives 21.
